seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 147 ++++++++++++++
 tb/tb_seq_divider.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per clock.
//               A start request latches x/y. The block then runs N
//               shift/compare/subtract steps and presents q/r with a
//               one-cycle done pulse. A zero divisor skips the iteration
//               entirely and reports dbz on the very next cycle.
//
// Parameters  : N - dividend / quotient width (must be >= 2)
//               M - divisor / remainder width
//
// Ports       : clk   - rising-edge clock
//               reset - synchronous active-high reset
//               start - begin a division (accepted in IDLE or DONE)
//               x     - dividend (unsigned, N bits)
//               y     - divisor  (unsigned, M bits)
//               q     - quotient (N bits), valid while done is high
//               r     - remainder (M bits), valid while done is high
//               busy  - high during the N iteration cycles
//               done  - one-cycle result-valid pulse
//               dbz   - divide-by-zero flag for the current result
//
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int N = 7,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [M-1:0] y,
    output logic [N-1:0] q,
    output logic [M-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    // Counter must be able to hold the value N itself.
    localparam int c_CNT_W = $clog2(N + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [N-1:0]       r_x;      // dividend, shifted left so the MSB is next
    logic [M-1:0]       r_y;      // latched divisor
    logic [M-1:0]       r_rem;    // partial remainder
    logic [N-1:0]       r_quo;    // quotient under construction
    logic [c_CNT_W-1:0] r_cnt;    // steps remaining
    logic [N-1:0]       r_q;
    logic [M-1:0]       r_r;
    logic               r_dbz;
    logic               r_busy;
    logic               r_done;

    logic [M:0]         w_p;
    logic               w_ge;
    logic [M-1:0]       w_rem_next;
    logic [N-1:0]       w_quo_next;

    // One restoring step. The partial remainder is always < y, so the
    // difference P - y is also < y and fits in M bits; computing it modulo
    // 2^M on the low bits gives the exact result.
    always_comb begin
        w_p        = {r_rem, r_x[N-1]};
        w_ge       = (w_p >= {1'b0, r_y});
        w_rem_next = w_ge ? (w_p[M-1:0] - r_y) : w_p[M-1:0];
        w_quo_next = {r_quo[N-2:0], w_ge};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_x   <= x;
                        r_y   <= y;
                        r_rem <= '0;
                        r_quo <= '0;
                        if (y != '0) begin
                            r_state <= c_RUN;
                            r_cnt   <= c_CNT_W'(N);
                            r_busy  <= 1'b1;
                        end else begin
                            // Zero divisor: publish the saturated result at once.
                            r_state <= c_DONE;
                            r_q     <= {N{1'b1}};
                            r_r     <= '0;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_state <= c_IDLE;
                    end
                end

                c_RUN: begin
                    // start is deliberately not looked at here.
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_x   <= r_x << 1;
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_q     <= w_quo_next;
                        r_r     <= w_rem_next;
                        r_dbz   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign q    = r_q;
    assign r    = r_r;
    assign busy = r_busy;
    assign done = r_done;
    assign dbz  = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider (N=7, M=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int N = 7;
    localparam int M = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] x;
    logic [M-1:0] y;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         busy;
    logic         done;
    logic         dbz;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_divider #(.N(N), .M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .x     (x),
        .y     (y),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    // Called 1 time unit after a rising edge; returns 1 time unit after the
    // start edge with start deasserted.
    task automatic do_start(input logic [N-1:0] xv, input logic [M-1:0] yv);
        x     = xv;
        y     = yv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat = number of cycles from the start edge until done is seen
    // (1 = the cycle right after the start edge). Bounded at 40.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 1;
        nbusy = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({q, r, dbz, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got q=%0d r=%0d dbz=%b busy=%b done=%b, expected all 0",
                     q, r, dbz, busy, done);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int lat, nb;
        do_start(7'd100, 4'd7);
        wait_done(lat, nb);
        vectors++;
        if (lat !== 8) begin
            miscompares++; $display("FAIL basic_latency: got %0d expected 8", lat);
        end
        vectors++;
        if (nb !== 7) begin
            miscompares++; $display("FAIL basic_busy_cycles: got %0d expected 7", nb);
        end
        vectors++;
        if (q !== 7'd14 || r !== 4'd2 || dbz !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_result: got q=%0d r=%0d dbz=%b expected q=14 r=2 dbz=0", q, r, dbz);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (q !== 7'd14 || r !== 4'd2) begin
            miscompares++;
            $display("FAIL basic_hold_idle: got q=%0d r=%0d expected q=14 r=2", q, r);
        end
    endtask

    task automatic test_div_zero;
        int lat, nb;
        do_start(7'd42, 4'd0);
        wait_done(lat, nb);
        vectors++;
        if (lat !== 1 || nb !== 0) begin
            miscompares++;
            $display("FAIL dbz_timing: got lat=%0d busy_cycles=%0d expected lat=1 busy_cycles=0", lat, nb);
        end
        vectors++;
        if (q !== 7'd127 || r !== 4'd0 || dbz !== 1'b1) begin
            miscompares++;
            $display("FAIL dbz_result: got q=%0d r=%0d dbz=%b expected q=127 r=0 dbz=1", q, r, dbz);
        end
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || dbz !== 1'b1) begin
            miscompares++;
            $display("FAIL dbz_after: got done=%b dbz=%b expected done=0 dbz=1", done, dbz);
        end
    endtask

    task automatic test_vectors;
        logic [N-1:0] tx [6] = '{7'd127, 7'd5, 7'd127, 7'd0, 7'd126, 7'd99};
        logic [M-1:0] ty [6] = '{4'd1,   4'd9, 4'd15,  4'd5, 4'd3,   4'd10};
        logic [N-1:0] eq [6] = '{7'd127, 7'd0, 7'd8,   7'd0, 7'd42,  7'd9};
        logic [M-1:0] er [6] = '{4'd0,   4'd5, 4'd7,   4'd0, 4'd0,   4'd9};
        int lat, nb;
        for (int i = 0; i < 6; i++) begin
            do_start(tx[i], ty[i]);
            wait_done(lat, nb);
            vectors++;
            if (lat !== 8 || q !== eq[i] || r !== er[i] || dbz !== 1'b0) begin
                miscompares++;
                $display("FAIL vector_%0d (%0d/%0d): got lat=%0d q=%0d r=%0d dbz=%b expected lat=8 q=%0d r=%0d dbz=0",
                         i, tx[i], ty[i], lat, q, r, dbz, eq[i], er[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start;
        int lat, nb;
        do_start(7'd100, 4'd7);
        @(posedge clk); #1;
        x = 7'd9; y = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x = '0; y = '0;
        wait_done(lat, nb);
        vectors++;
        if (lat + 2 !== 8 || q !== 7'd14 || r !== 4'd2) begin
            miscompares++;
            $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d expected lat=8 q=14 r=2", lat + 2, q, r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lat, nb, gap;
        logic seen_low;
        x = 7'd60; y = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        wait_done(lat, nb);
        vectors++;
        if (lat !== 8 || q !== 7'd15 || r !== 4'd0) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d expected lat=8 q=15 r=0", lat, q, r);
        end
        gap = 0;
        seen_low = 1'b0;
        do begin
            @(posedge clk); #1;
            gap++;
            if (done === 1'b0) seen_low = 1'b1;
        end while (done !== 1'b1 && gap < 40);
        vectors++;
        if (gap !== 8 || seen_low !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_gap: got gap=%0d done_dropped=%b expected gap=8 done_dropped=1", gap, seen_low);
        end
        vectors++;
        if (q !== 7'd15 || r !== 4'd0 || dbz !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got q=%0d r=%0d dbz=%b expected q=15 r=0 dbz=0", q, r, dbz);
        end
        start = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset_mid_run;
        int lat, nb;
        logic seen_done;
        do_start(7'd100, 4'd7);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({q, r, dbz, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs: got q=%0d r=%0d dbz=%b busy=%b done=%b expected all 0",
                     q, r, dbz, busy, done);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
        end
        vectors++;
        if (seen_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_no_done: got activity=%b expected 0", seen_done);
        end
        do_start(7'd50, 4'd6);
        wait_done(lat, nb);
        vectors++;
        if (lat !== 8 || q !== 7'd8 || r !== 4'd2 || dbz !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_restart: got lat=%0d q=%0d r=%0d dbz=%b expected lat=8 q=8 r=2 dbz=0",
                     lat, q, r, dbz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_priority;
        x = 7'd20; y = 4'd5; start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_priority: got busy=%b done=%b q=%0d expected 0 0 0", busy, done, q);
        end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_priority_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_vectors;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid_run;
        test_reset_priority;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
